// File: rtl/round_controller_pkg.sv
// Shared constants for the round controller: FSM state codes, target sum, LED codes.
// Used by round_controller and its optional round_timer (built with ROUND_TIMER_EN).
package round_controller_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PLAY  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_WIN   = 3'd3;
    localparam logic [2:0] ST_LOSE  = 3'd4;

    localparam logic [4:0] TARGET_SUM = 5'd15;

    localparam logic [1:0] LED_IDLE = 2'b00;
    localparam logic [1:0] LED_PLAY = 2'b01;
    localparam logic [1:0] LED_WIN  = 2'b10;

    localparam int SECS_W = 8;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/round_controller_timer.sv
// round_timer: per-round countdown, a prescaler dividing clk into one-second ticks
// feeding a seconds down-counter; expired stays high once the count reaches zero.
module round_timer
    import round_controller_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int ROUND_SECONDS = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

    logic [PRE_W-1:0]  pre;
    logic [SECS_W-1:0] secs;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre  <= '0;
            secs <= '0;
        end else if (reload) begin
            pre  <= '0;
            secs <= SECS_W'(ROUND_SECONDS);
        end else if (enable && secs != '0) begin
            if (pre == PRE_LAST) begin
                pre  <= '0;
                secs <= secs - 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    assign expired = (secs == '0);

endmodule

// File: rtl/round_controller.sv
// round_controller: sum-to-15 game FSM with running sum, load budget and saturating score.
// Define ROUND_TIMER_EN to add a per-round countdown that loses the round on expiry.
module round_controller
    import round_controller_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int ROUND_SECONDS = 30,
    parameter int MAX_LOADS     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       load,
    input  logic [3:0] operand,
    output logic [3:0] sum,
    output logic [1:0] leds,
    output logic [3:0] score,
    output logic [3:0] loads_left,
    output logic       busy,
    output logic       timeout
);

    if (TICKS_PER_SEC < 1 || ROUND_SECONDS < 1 || ROUND_SECONDS > 255 ||
        MAX_LOADS < 1 || MAX_LOADS > 15) begin : g_bad_cfg
        $error("round_controller: parameter out of range");
    end

    // Reset asserts immediately but is released only after two clean clk edges.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    logic [2:0] state;
    logic [4:0] acc;
    logic       start_round;
    logic       expire_hit;

    assign start_round = start &&
                         (state == ST_IDLE || state == ST_WIN || state == ST_LOSE);

`ifdef ROUND_TIMER_EN
    logic expired;
    logic timeout_r;

    round_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .ROUND_SECONDS(ROUND_SECONDS)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (start_round),
        .enable (busy),
        .expired(expired)
    );

    // A load in the expiry cycle takes priority; expiry is seen again on return to PLAY.
    assign expire_hit = (state == ST_PLAY) && !load && expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          timeout_r <= 1'b0;
        else if (start_round) timeout_r <= 1'b0;
        else if (expire_hit)  timeout_r <= 1'b1;
    end

    assign timeout = timeout_r;
`else
    assign expire_hit = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            loads_left <= '0;
            score      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start_round) begin
                        state      <= ST_PLAY;
                        acc        <= '0;
                        loads_left <= 4'(MAX_LOADS);
                    end
                end
                ST_PLAY: begin
                    if (load) begin
                        // acc never exceeds 15 in PLAY, so the 5-bit add cannot wrap.
                        acc        <= acc + {1'b0, operand};
                        loads_left <= loads_left - 4'd1;
                        state      <= ST_CHECK;
                    end else if (expire_hit) begin
                        state <= ST_LOSE;
                    end
                end
                ST_CHECK: begin
                    if (acc == TARGET_SUM) begin
                        state <= ST_WIN;
                        score <= sat_inc4(score);
                    end else if (acc > TARGET_SUM) begin
                        state <= ST_LOSE;
                        acc   <= TARGET_SUM;
                    end else if (loads_left == 4'd0) begin
                        state <= ST_LOSE;
                    end else begin
                        state <= ST_PLAY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sum  = acc[4] ? 4'hF : acc[3:0];
    assign busy = (state == ST_PLAY) || (state == ST_CHECK);

    always_comb begin
        case (state)
            ST_IDLE: leds = LED_IDLE;
            ST_WIN:  leds = LED_WIN;
            default: leds = LED_PLAY;
        endcase
    end

endmodule

// File: tb/tb_round_controller.sv
// Directed plus randomized bench for round_controller; the reference model tracks the
// round in plain arithmetic (sum, loads used, edges since start) and the expected score.
module tb_round_controller;

    localparam int TPS  = 4;
    localparam int SECS = 2;
    localparam int MAXL = 4;
`ifdef ROUND_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif
    // First edge after start at which an idle PLAY cycle sees the timer expired.
    localparam int EXPIRY_EDGE = TPS * SECS + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       load = 1'b0;
    logic [3:0] operand = 4'd0;
    logic [3:0] sum;
    logic [1:0] leds;
    logic [3:0] score;
    logic [3:0] loads_left;
    logic       busy;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int m_score = 0;

    round_controller #(
        .TICKS_PER_SEC(TPS),
        .ROUND_SECONDS(SECS),
        .MAX_LOADS    (MAXL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load      (load),
        .operand   (operand),
        .sum       (sum),
        .leds      (leds),
        .score     (score),
        .loads_left(loads_left),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_sum, input int e_leds,
                             input int e_score, input int e_ll, input int e_busy,
                             input int e_to);
        check({tag, ".sum"},        8'(sum),        8'(e_sum));
        check({tag, ".leds"},       8'(leds),       8'(e_leds));
        check({tag, ".score"},      8'(score),      8'(e_score));
        check({tag, ".loads_left"}, 8'(loads_left), 8'(e_ll));
        check({tag, ".busy"},       8'(busy),       8'(e_busy));
        check({tag, ".timeout"},    8'(timeout),    8'(e_to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_round();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_op(input int v);
        operand = 4'(v);
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    function automatic int win_score(input int s);
        return (s >= 15) ? 15 : s + 1;
    endfunction

    task automatic rand_round(input int idx);
        int  m_sum = 0;
        int  used  = 0;
        int  k     = 0;
        int  gap;
        int  op;
        bit  done  = 1'b0;
        bit  won   = 1'b0;
        bit  to    = 1'b0;
        string tag;
        tag = $sformatf("rand%0d", idx);
        begin_round();
        while (!done) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap && !done; g++) begin
                if (TIMER_ON && k + 1 >= EXPIRY_EDGE) begin
                    to   = 1'b1;
                    done = 1'b1;
                end
                tick();
                k++;
            end
            if (done) break;
            op = ($urandom_range(0, 2) == 0) ? 15 - m_sum : $urandom_range(0, 15);
            load_op(op);
            k++;
            m_sum += op;
            used++;
            tick();
            k++;
            if (m_sum == 15) begin
                won  = 1'b1;
                done = 1'b1;
            end else if (m_sum > 15 || used == MAXL) begin
                done = 1'b1;
            end
        end
        if (won) m_score = win_score(m_score);
        check_all(tag, (m_sum > 15) ? 15 : m_sum, won ? 2 : 1, m_score, MAXL - used, 0, to);
    endtask

    initial begin
        // Reset values, then release through the internal synchroniser.
        rst = 1'b0;
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) tick();
        check_all("post_reset", 0, 0, 0, 0, 0, 0);

        // start and load together in IDLE: only start counts.
        start   = 1'b1;
        load    = 1'b1;
        operand = 4'd5;
        tick();
        start = 1'b0;
        load  = 1'b0;
        check_all("start_load", 0, 1, 0, MAXL, 1, 0);

        // 7 + 8 wins; start during PLAY is ignored.
        load_op(7);
        tick();
        check_all("after7", 7, 1, 0, MAXL - 1, 1, 0);
        begin_round();
        check_all("start_in_play", 7, 1, 0, MAXL - 1, 1, 0);
        load_op(8);
        check_all("check_cycle", 15, 1, 0, MAXL - 2, 1, 0);
        tick();
        m_score = 1;
        check_all("win", 15, 2, m_score, 2, 0, 0);
        load_op(3);
        check_all("load_in_win", 15, 2, m_score, 2, 0, 0);

        // 9 + 9 overshoots: lose with sum held at 15.
        begin_round();
        load_op(9);
        tick();
        load_op(9);
        tick();
        check_all("lose_over", 15, 1, m_score, MAXL - 2, 0, 0);

        // Load budget exhausted.
        begin_round();
        for (int i = 0; i < MAXL; i++) begin
            load_op(1);
            tick();
        end
        check_all("lose_loads", MAXL, 1, m_score, 0, 0, 0);

        // Zero operand consumes a load only, then 15 wins.
        begin_round();
        load_op(0);
        tick();
        check_all("zero_op", 0, 1, m_score, MAXL - 1, 1, 0);
        load_op(15);
        tick();
        m_score = win_score(m_score);
        check_all("win_after_zero", 15, 2, m_score, MAXL - 2, 0, 0);

        if (TIMER_ON) begin
            // Idle round expires on edge EXPIRY_EDGE.
            begin_round();
            repeat (EXPIRY_EDGE - 1) tick();
            check_all("pre_expiry", 0, 1, m_score, MAXL, 1, 0);
            tick();
            check_all("expiry", 0, 1, m_score, MAXL, 0, 1);
            // Load in the expiry cycle goes through CHECK before the loss.
            begin_round();
            check_all("timeout_cleared", 0, 1, m_score, MAXL, 1, 0);
            repeat (EXPIRY_EDGE - 1) tick();
            load_op(3);
            check_all("load_beats_expiry", 3, 1, m_score, MAXL - 1, 1, 0);
            tick();
            check_all("back_to_play", 3, 1, m_score, MAXL - 1, 1, 0);
            tick();
            check_all("expiry_after_check", 3, 1, m_score, MAXL - 1, 0, 1);
        end else begin
            // Without the timer a round waits indefinitely.
            begin_round();
            repeat (4 * EXPIRY_EDGE) tick();
            check_all("no_timer", 0, 1, m_score, MAXL, 1, 0);
            load_op(15);
            tick();
            m_score = win_score(m_score);
            check_all("no_timer_win", 15, 2, m_score, MAXL - 1, 0, 0);
        end

        for (int r = 0; r < 30; r++) rand_round(r);

        // Sixteen straight wins saturate the score.
        for (int r = 0; r < 16; r++) begin
            begin_round();
            load_op(15);
            tick();
            m_score = win_score(m_score);
        end
        check_all("saturate", 15, 2, 15, MAXL - 1, 0, 0);

        // Asynchronous reset in the middle of PLAY.
        begin_round();
        load_op(4);
        tick();
        check_all("mid_play", 4, 1, 15, MAXL - 1, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0);
        m_score = 0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        begin_round();
        check_all("restart", 0, 1, m_score, MAXL, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
